// File: rtl/kbd_pkg.sv
// kbd_pkg: constants and types shared by the PS/2 keyboard front end.
//   Scan-code prefixes and special keys, the Pause-sequence skip count,
//   receiver frame-state encodings, the decoded key-event record and an
//   odd-parity helper.
// Optional feature macro: KBD_PARITY_CHECK_EN (used by ps2_rx).
package kbd_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_PAUSE  = 8'hE1;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;

    // Bytes that still follow an E1 in the Pause make/break sequence.
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    // Receiver frame states.
    localparam logic [1:0] RX_IDLE   = 2'd0;
    localparam logic [1:0] RX_DATA   = 2'd1;
    localparam logic [1:0] RX_PARITY = 2'd2;
    localparam logic [1:0] RX_STOP   = 2'd3;

    typedef struct packed {
        logic [7:0] code;
        logic       shift;
        logic       ext;
    } key_evt_t;

    // PS/2 uses odd parity: data bits plus parity bit hold an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 frame receiver.
//   Synchronises ps2_clk/ps2_dat, glitch-filters ps2_clk, samples data on
//   accepted falling edges and assembles start/8 data (LSB first)/parity/stop
//   frames. A stalled frame is aborted after TIMEOUT_CYC cycles without an edge.
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   ps2_clk, ps2_dat  raw asynchronous PS/2 lines
//   rx_byte           received byte (valid while byte_vld is high)
//   byte_vld          one-cycle pulse on the stop-bit edge of a good frame
//   err               one-cycle pulse on bad start/stop, timeout or parity
// Optional feature macro: KBD_PARITY_CHECK_EN enables the odd-parity check.
module ps2_rx
    import kbd_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 4,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] rx_byte,
    output logic       byte_vld,
    output logic       err
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

    logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic          clk_f_q, clk_f_d;
    logic [FW-1:0] flt_cnt_q, flt_cnt_d;
    logic          edge_acc, fall;
    logic [1:0]    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    sh_q, sh_d;
    logic [TW-1:0] to_q, to_d;
    logic          par_ok;
`ifdef KBD_PARITY_CHECK_EN
    logic          par_q, par_d;
    assign par_ok = odd_parity_ok(sh_q, par_q);
`else
    assign par_ok = 1'b1;
`endif

    // Filtered clock only flips after FILTER_LEN consecutive differing samples.
    always_comb begin
        clk_f_d   = clk_f_q;
        flt_cnt_d = flt_cnt_q;
        edge_acc  = 1'b0;
        if (clk_s2_q == clk_f_q) begin
            flt_cnt_d = '0;
        end else if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
            clk_f_d   = clk_s2_q;
            flt_cnt_d = '0;
            edge_acc  = 1'b1;
        end else begin
            flt_cnt_d = flt_cnt_q + 1'b1;
        end
    end

    assign fall = edge_acc & ~clk_s2_q;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        sh_d      = sh_q;
`ifdef KBD_PARITY_CHECK_EN
        par_d     = par_q;
`endif
        byte_vld  = 1'b0;
        err       = 1'b0;
        to_d      = (state_q == RX_IDLE || edge_acc) ? '0 : to_q + 1'b1;

        if (state_q != RX_IDLE && !edge_acc && to_q == TW'(TIMEOUT_CYC - 1)) begin
            err     = 1'b1;
            state_d = RX_IDLE;
            to_d    = '0;
        end else if (fall) begin
            case (state_q)
                RX_IDLE: begin
                    if (!dat_s2_q) begin
                        state_d   = RX_DATA;
                        bit_cnt_d = '0;
                    end else begin
                        err = 1'b1;
                    end
                end
                RX_DATA: begin
                    sh_d      = {dat_s2_q, sh_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
                end
                RX_PARITY: begin
`ifdef KBD_PARITY_CHECK_EN
                    par_d   = dat_s2_q;
`endif
                    state_d = RX_STOP;
                end
                default: begin
                    state_d = RX_IDLE;
                    if (dat_s2_q && par_ok) byte_vld = 1'b1;
                    else                    err      = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // Lines idle high, so sync and filter start high: no spurious edge.
            clk_s1_q  <= 1'b1;
            clk_s2_q  <= 1'b1;
            dat_s1_q  <= 1'b1;
            dat_s2_q  <= 1'b1;
            clk_f_q   <= 1'b1;
            flt_cnt_q <= '0;
            state_q   <= RX_IDLE;
            bit_cnt_q <= '0;
            sh_q      <= '0;
            to_q      <= '0;
`ifdef KBD_PARITY_CHECK_EN
            par_q     <= 1'b0;
`endif
        end else begin
            clk_s1_q  <= ps2_clk;
            clk_s2_q  <= clk_s1_q;
            dat_s1_q  <= ps2_dat;
            dat_s2_q  <= dat_s1_q;
            clk_f_q   <= clk_f_d;
            flt_cnt_q <= flt_cnt_d;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            sh_q      <= sh_d;
            to_q      <= to_d;
`ifdef KBD_PARITY_CHECK_EN
            par_q     <= par_d;
`endif
        end
    end

    assign rx_byte = sh_q;

endmodule

// File: rtl/kbd_ps2_scan.sv
// kbd_ps2_scan: PS/2 keyboard front end for the scan-code-to-ASCII translator.
//   ps2_rx assembles bytes; this level resolves E0/F0/E1 prefixes, tracks both
//   Shift keys and strobes one {shift, code, ext} event per make code.
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   ps2_clk, ps2_dat  raw asynchronous PS/2 lines
//   code, shift, ext  last make event (held until the next stb)
//   stb               one-cycle pulse when code/shift/ext are new
//   key_held          high from the last make until its matching break
//   frame_err         one-cycle pulse on a receive error
// Optional feature macro: KBD_PARITY_CHECK_EN enables the odd-parity check.
module kbd_ps2_scan
    import kbd_pkg::*;
#(
    parameter int unsigned FILTER_LEN  = 4,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] code,
    output logic       shift,
    output logic       ext,
    output logic       stb,
    output logic       key_held,
    output logic       frame_err
);

    logic [7:0] rx_byte;
    logic       byte_vld, rx_err;

    ps2_rx #(
        .FILTER_LEN  (FILTER_LEN),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_rx (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_dat  (ps2_dat),
        .rx_byte  (rx_byte),
        .byte_vld (byte_vld),
        .err      (rx_err)
    );

    key_evt_t   evt_q, evt_d;
    logic [2:0] skip_q, skip_d;
    logic       ext_flag_q, ext_flag_d, brk_flag_q, brk_flag_d;
    logic       shift_l_q, shift_l_d, shift_r_q, shift_r_d;
    logic       stb_q, stb_d, held_q, held_d, ferr_q, ferr_d;

    always_comb begin
        evt_d      = evt_q;
        skip_d     = skip_q;
        ext_flag_d = ext_flag_q;
        brk_flag_d = brk_flag_q;
        shift_l_d  = shift_l_q;
        shift_r_d  = shift_r_q;
        held_d     = held_q;
        stb_d      = 1'b0;
        ferr_d     = rx_err;

        if (byte_vld) begin
            if (skip_q != 3'd0) begin
                skip_d = skip_q - 1'b1;
            end else if (rx_byte == SC_PAUSE) begin
                skip_d = PAUSE_SKIP;
            end else if (rx_byte == SC_EXT) begin
                ext_flag_d = 1'b1;
            end else if (rx_byte == SC_BREAK) begin
                brk_flag_d = 1'b1;
            end else begin
                ext_flag_d = 1'b0;
                brk_flag_d = 1'b0;
                if (rx_byte == SC_LSHIFT && !ext_flag_q) begin
                    shift_l_d = !brk_flag_q;
                end else if (rx_byte == SC_RSHIFT && !ext_flag_q) begin
                    shift_r_d = !brk_flag_q;
                end else if (rx_byte == SC_LSHIFT) begin
                    // E0 12 is the fake shift some keyboards wrap around keys.
                end else if (!brk_flag_q) begin
                    evt_d.code  = rx_byte;
                    evt_d.shift = shift_l_q | shift_r_q;
                    evt_d.ext   = ext_flag_q;
                    stb_d       = 1'b1;
                    held_d      = 1'b1;
                end else if (rx_byte == evt_q.code && ext_flag_q == evt_q.ext) begin
                    held_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            evt_q      <= '0;
            skip_q     <= '0;
            ext_flag_q <= 1'b0;
            brk_flag_q <= 1'b0;
            shift_l_q  <= 1'b0;
            shift_r_q  <= 1'b0;
            stb_q      <= 1'b0;
            held_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            evt_q      <= evt_d;
            skip_q     <= skip_d;
            ext_flag_q <= ext_flag_d;
            brk_flag_q <= brk_flag_d;
            shift_l_q  <= shift_l_d;
            shift_r_q  <= shift_r_d;
            stb_q      <= stb_d;
            held_q     <= held_d;
            ferr_q     <= ferr_d;
        end
    end

    assign code      = evt_q.code;
    assign shift     = evt_q.shift;
    assign ext       = evt_q.ext;
    assign stb       = stb_q;
    assign key_held  = held_q;
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_kbd_ps2_scan.sv
`timescale 1ns/1ps
module tb_kbd_ps2_scan;

    localparam int unsigned TO   = 1000;
    localparam int          HALF = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2_clk, ps2_dat;
    logic [7:0] code;
    logic       shift, ext, stb, key_held, frame_err;

    kbd_ps2_scan #(
        .FILTER_LEN  (4),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_dat   (ps2_dat),
        .code      (code),
        .shift     (shift),
        .ext       (ext),
        .stb       (stb),
        .key_held  (key_held),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] code;
        logic       sh;
        logic       ex;
    } exp_t;

    exp_t exp_q[$];
    int   err_exp  = 0;
    int   checks   = 0;
    int   failures = 0;

    // Reference model of the decoder: prefix state, pressed shifts, last make.
    int         m_skip;
    bit         m_ext, m_brk, m_shl, m_shr, m_held, m_last_ext;
    logic [7:0] m_last;

    task automatic model_reset();
        m_skip = 0; m_ext = 0; m_brk = 0; m_shl = 0; m_shr = 0;
        m_held = 0; m_last = 8'h00; m_last_ext = 0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        exp_t e;
        if (m_skip > 0) begin
            m_skip--;
            return;
        end
        case (b)
            8'hE1: m_skip = 7;
            8'hE0: m_ext = 1;
            8'hF0: m_brk = 1;
            default: begin
                if (!m_ext && (b == 8'h12 || b == 8'h59)) begin
                    if (b == 8'h12) m_shl = !m_brk;
                    else            m_shr = !m_brk;
                end else if (m_ext && b == 8'h12) begin
                    // ignored
                end else if (!m_brk) begin
                    e.code = b; e.sh = m_shl || m_shr; e.ex = m_ext;
                    exp_q.push_back(e);
                    m_last = b; m_last_ext = m_ext; m_held = 1;
                end else if (b == m_last && m_ext == m_last_ext) begin
                    m_held = 0;
                end
                m_ext = 0; m_brk = 0;
            end
        endcase
    endtask

    task automatic ps2_bit(input logic b);
        ps2_dat = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit bad_stop);
        logic par;
        bit   good;
        par  = ~^b ^ flip_par;
`ifdef KBD_PARITY_CHECK_EN
        good = !bad_stop && !flip_par;
`else
        good = !bad_stop;
`endif
        if (good) model_byte(b);
        else      err_exp++;
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit(par);
        ps2_bit(!bad_stop);
        ps2_dat = 1'b1;
        repeat (2 * HALF) @(negedge clk);
    endtask

    task automatic check_held(input string name);
        checks++;
        if (key_held !== m_held) begin
            failures++;
            $display("FAIL %s key_held got=%0b want=%0b", name, key_held, m_held);
        end
    endtask

    task automatic send_seq(input logic [7:0] seq[$], input string name);
        foreach (seq[i]) send_frame(seq[i], 0, 0);
        check_held(name);
    endtask

    // Monitor: every stb/frame_err is matched against the scoreboard.
    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            if (stb) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_stb got code=%h shift=%0b ext=%0b want none",
                             code, shift, ext);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (code !== e.code || shift !== e.sh || ext !== e.ex || key_held !== 1'b1) begin
                        failures++;
                        $display("FAIL stb_event got code=%h shift=%0b ext=%0b held=%0b want code=%h shift=%0b ext=%0b held=1",
                                 code, shift, ext, key_held, e.code, e.sh, e.ex);
                    end
                end
            end
            if (frame_err) begin
                checks++;
                if (err_exp == 0) begin
                    failures++;
                    $display("FAIL unexpected_frame_err got=1 want=0");
                end else begin
                    err_exp--;
                end
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pool[11];
        logic [7:0] b;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        reset   = 1'b1;
        model_reset();
        repeat (5) @(negedge clk);
        checks++;
        if ({code, shift, ext, stb, key_held, frame_err} !== 13'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0", {code, shift, ext, stb, key_held, frame_err});
        end
        reset = 1'b0;
        repeat (5) @(negedge clk);

        send_seq('{8'h1C}, "single_make");
        send_seq('{8'h12, 8'h1C, 8'hF0, 8'h1C}, "shift_make_break");
        send_seq('{8'hF0, 8'h12, 8'h29}, "shift_release");
        send_seq('{8'hE0, 8'h75}, "ext_make");
        send_seq('{8'hE0, 8'hF0, 8'h75}, "ext_break");
        send_seq('{8'h59, 8'hE0, 8'h12, 8'h2A, 8'hF0, 8'h59, 8'h2A}, "rshift_fake_typematic");
        send_seq('{8'hF0, 8'hF0, 8'hE0, 8'hE0, 8'h2A}, "double_prefix");

        send_frame(8'h1C, 1, 0);
        check_held("flip_parity");
        send_frame(8'h33, 0, 1);
        check_held("bad_stop");

        // Lone falling edge with data high: a bad start bit.
        err_exp++;
        ps2_bit(1'b1);
        ps2_dat = 1'b1;
        repeat (2 * HALF) @(negedge clk);

        // Five bits then silence: timeout.
        err_exp++;
        for (int i = 0; i < 5; i++) ps2_bit(1'b0);
        ps2_dat = 1'b1;
        repeat (TO + 50) @(negedge clk);
        send_seq('{8'h29}, "after_timeout");

        send_seq('{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h1C}, "pause_skip");

        // Reset in the middle of a frame.
        for (int i = 0; i < 4; i++) ps2_bit(1'b0);
        ps2_dat = 1'b1;
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({code, shift, ext, stb, key_held, frame_err} !== 13'd0) begin
            failures++;
            $display("FAIL midframe_reset got=%h want=0", {code, shift, ext, stb, key_held, frame_err});
        end
        model_reset();
        reset = 1'b0;
        repeat (5) @(negedge clk);
        send_seq('{8'h12, 8'h1C}, "after_reset");

        pool = '{8'h12, 8'h59, 8'hE0, 8'hF0, 8'h1C, 8'h29, 8'h75, 8'h14, 8'h77, 8'hE1, 8'h00};
        for (int n = 0; n < 80; n++) begin
            int k;
            k = $urandom_range(0, 10);
            b = (k == 10) ? 8'($urandom_range(0, 255)) : pool[k];
            send_frame(b, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
            if (n % 8 == 7) check_held("random_held");
        end

        repeat (50) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || err_exp != 0) begin
            failures++;
            $display("FAIL drain got=stb_left:%0d err_left:%0d want=0:0", exp_q.size(), err_exp);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
